// File: rtl/reg_bank_writer.sv
// Write side of the 32-entry general-purpose register file feeding the bus mux.
// One-hot load decode from wr_sel, plus write-tracking status for control/debug.
module reg_bank_writer #(
  parameter int WIDTH    = 32,
  parameter int R0_GATED = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             wr_en,
  input  logic [4:0]       wr_sel,
  input  logic             ba_out,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] r16,
  output logic [WIDTH-1:0] r17,
  output logic [WIDTH-1:0] r18,
  output logic [WIDTH-1:0] r19,
  output logic [WIDTH-1:0] r20,
  output logic [WIDTH-1:0] r21,
  output logic [WIDTH-1:0] r22,
  output logic [WIDTH-1:0] r23,
  output logic [WIDTH-1:0] r24,
  output logic [WIDTH-1:0] r25,
  output logic [WIDTH-1:0] r26,
  output logic [WIDTH-1:0] r27,
  output logic [WIDTH-1:0] r28,
  output logic [WIDTH-1:0] r29,
  output logic [WIDTH-1:0] r30,
  output logic [WIDTH-1:0] r31,
  output logic [31:0]      written,
  output logic [15:0]      wr_count,
  output logic [4:0]       last_sel,
  output logic             wr_ack
);

  logic [WIDTH-1:0] regs [32];
  logic [31:0]      load;

  always_comb begin
    load = '0;
    if (wr_en) load[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      written  <= '0;
      wr_count <= '0;
      last_sel <= '0;
      wr_ack   <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (load[i]) regs[i] <= bus_in;
      end
      written <= written | load;
      if (wr_en) begin
        last_sel <= wr_sel;
        // saturate rather than wrap so software can detect overflow
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
      wr_ack <= wr_en;
    end
  end

  // gating only masks the visible r0; the stored value survives
  assign r0  = ((R0_GATED != 0) && ba_out) ? '0 : regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];
  assign r16 = regs[16];
  assign r17 = regs[17];
  assign r18 = regs[18];
  assign r19 = regs[19];
  assign r20 = regs[20];
  assign r21 = regs[21];
  assign r22 = regs[22];
  assign r23 = regs[23];
  assign r24 = regs[24];
  assign r25 = regs[25];
  assign r26 = regs[26];
  assign r27 = regs[27];
  assign r28 = regs[28];
  assign r29 = regs[29];
  assign r30 = regs[30];
  assign r31 = regs[31];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: a gated and an ungated instance share stimulus and
// are compared every negedge against an array-based model of the register file.
module tb_reg_bank_writer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic        ba_out;

  wire [31:0] g_r [32];
  wire [31:0] g_written;
  wire [15:0] g_count;
  wire [4:0]  g_last;
  wire        g_ack;
  wire [31:0] u_r [32];
  wire [31:0] u_written;
  wire [15:0] u_count;
  wire [4:0]  u_last;
  wire        u_ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank_writer #(.WIDTH(32), .R0_GATED(1)) u_gated (
    .clk(clk), .clr(clr), .bus_in(bus_in), .wr_en(wr_en), .wr_sel(wr_sel), .ba_out(ba_out),
    .r0(g_r[0]), .r1(g_r[1]), .r2(g_r[2]), .r3(g_r[3]), .r4(g_r[4]), .r5(g_r[5]),
    .r6(g_r[6]), .r7(g_r[7]), .r8(g_r[8]), .r9(g_r[9]), .r10(g_r[10]), .r11(g_r[11]),
    .r12(g_r[12]), .r13(g_r[13]), .r14(g_r[14]), .r15(g_r[15]), .r16(g_r[16]), .r17(g_r[17]),
    .r18(g_r[18]), .r19(g_r[19]), .r20(g_r[20]), .r21(g_r[21]), .r22(g_r[22]), .r23(g_r[23]),
    .r24(g_r[24]), .r25(g_r[25]), .r26(g_r[26]), .r27(g_r[27]), .r28(g_r[28]), .r29(g_r[29]),
    .r30(g_r[30]), .r31(g_r[31]),
    .written(g_written), .wr_count(g_count), .last_sel(g_last), .wr_ack(g_ack)
  );

  reg_bank_writer #(.WIDTH(32), .R0_GATED(0)) u_ungated (
    .clk(clk), .clr(clr), .bus_in(bus_in), .wr_en(wr_en), .wr_sel(wr_sel), .ba_out(ba_out),
    .r0(u_r[0]), .r1(u_r[1]), .r2(u_r[2]), .r3(u_r[3]), .r4(u_r[4]), .r5(u_r[5]),
    .r6(u_r[6]), .r7(u_r[7]), .r8(u_r[8]), .r9(u_r[9]), .r10(u_r[10]), .r11(u_r[11]),
    .r12(u_r[12]), .r13(u_r[13]), .r14(u_r[14]), .r15(u_r[15]), .r16(u_r[16]), .r17(u_r[17]),
    .r18(u_r[18]), .r19(u_r[19]), .r20(u_r[20]), .r21(u_r[21]), .r22(u_r[22]), .r23(u_r[23]),
    .r24(u_r[24]), .r25(u_r[25]), .r26(u_r[26]), .r27(u_r[27]), .r28(u_r[28]), .r29(u_r[29]),
    .r30(u_r[30]), .r31(u_r[31]),
    .written(u_written), .wr_count(u_count), .last_sel(u_last), .wr_ack(u_ack)
  );

  // reference model: storage array, set of written indices, saturating counter
  logic [31:0] m_mem [32];
  logic        m_wr [32];
  int          m_count;
  int          m_last;
  logic        m_ack;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] <= 32'h0;
        m_wr[i]  <= 1'b0;
      end
      m_count <= 0;
      m_last  <= 0;
      m_ack   <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      if (wr_en) begin
        m_mem[wr_sel] <= bus_in;
        m_wr[wr_sel]  <= 1'b1;
        m_last        <= int'(wr_sel);
        m_count       <= (m_count >= 65535) ? 65535 : m_count + 1;
      end
      m_ack <= wr_en;
    end
  end

  always @(posedge clk) begin
    if (!clr) assert (!$isunknown(wr_en)) else $error("wr_en unknown outside reset");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h at %0t", name, idx, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] wmask;
      wmask = '0;
      for (int i = 0; i < 32; i++) begin
        wmask[i] = m_wr[i];
        chk("r_gated", i, g_r[i], (i == 0 && ba_out) ? 32'h0 : m_mem[i]);
        chk("r_ungated", i, u_r[i], m_mem[i]);
      end
      chk("written", 0, g_written, wmask);
      chk("wr_count", 0, {16'h0, g_count}, 32'(m_count));
      chk("last_sel", 0, {27'h0, g_last}, 32'(m_last));
      chk("wr_ack", 0, {31'h0, g_ack}, {31'h0, m_ack});
      chk("written_u", 0, u_written, wmask);
      chk("wr_count_u", 0, {16'h0, u_count}, 32'(m_count));
      chk("wr_ack_u", 0, {31'h0, u_ack}, {31'h0, m_ack});
    end
  end

  task automatic drive(input logic c, input logic en, input logic [4:0] sel,
                       input logic [31:0] d, input logic ba);
    clr = c; wr_en = en; wr_sel = sel; bus_in = d; ba_out = ba;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; wr_en = 1'b0; wr_sel = '0; bus_in = '0; ba_out = 1'b0;
    #1;

    // reset then idle
    drive(1, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 0, 0);
    chk("idle_count", 0, {16'h0, g_count}, 32'h0);
    chk("idle_written", 0, g_written, 32'h0);

    // single write
    drive(0, 1, 5, 32'hDEADBEEF, 0);
    chk("single_r5", 5, g_r[5], 32'hDEADBEEF);
    chk("single_written", 0, g_written, 32'h20);
    chk("single_count", 0, {16'h0, g_count}, 32'h1);
    chk("single_ack", 0, {31'h0, g_ack}, 32'h1);
    drive(0, 0, 0, 0, 0);
    chk("single_ack_drop", 0, {31'h0, g_ack}, 32'h0);

    // sweep from clean reset
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) drive(0, 1, 5'(i), 32'h100 + 32'(i), 0);
    chk("sweep_written", 0, g_written, 32'hFFFFFFFF);
    chk("sweep_count", 0, {16'h0, g_count}, 32'd32);
    chk("sweep_r31", 31, g_r[31], 32'h11F);
    drive(0, 0, 0, 0, 0);

    // r0 gating
    drive(0, 1, 0, 32'h1234, 0);
    drive(0, 0, 0, 0, 1);
    chk("gate_on_g", 0, g_r[0], 32'h0);
    chk("gate_on_u", 0, u_r[0], 32'h1234);
    drive(0, 0, 0, 0, 0);
    chk("gate_off_g", 0, g_r[0], 32'h1234);

    // clr wins over a simultaneous write
    drive(1, 1, 7, 32'hFFFFFFFF, 0);
    chk("clrwr_r7", 7, g_r[7], 32'h0);
    chk("clrwr_written", 0, g_written, 32'h0);
    chk("clrwr_count", 0, {16'h0, g_count}, 32'h0);
    chk("clrwr_ack", 0, {31'h0, g_ack}, 32'h0);

    // same-index rewrite then random traffic with occasional reset
    drive(0, 1, 3, 32'hAAAA0001, 0);
    drive(0, 1, 3, 32'hBBBB0002, 0);
    chk("rewrite_r3", 3, g_r[3], 32'hBBBB0002);
    chk("rewrite_count", 0, {16'h0, g_count}, 32'd2);
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom), $urandom, 1'($urandom));

    // saturation
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 1, 5'($urandom), $urandom, 1'($urandom));
    chk("sat_count", 0, {16'h0, g_count}, 32'hFFFF);
    drive(0, 1, 9, 32'h0BADF00D, 0);
    chk("sat_r9", 9, g_r[9], 32'h0BADF00D);
    chk("sat_last", 0, {27'h0, g_last}, 32'd9);
    chk("sat_hold", 0, {16'h0, g_count}, 32'hFFFF);
    drive(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
